// File: rtl/shift_deser_17b_if.sv
// Handshake/bus bundle for the MSB-first serial deserializer.
// master drives the frame controls; slave is the receiver side.
interface shift_deser_17b_if #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
);
    logic             init;
    logic             start;
    logic             serIn;
    logic             sh_en;
    logic             ack;
    logic [WIDTH-1:0] dataOut;
    logic             valid;
    logic             busy;
    logic [CNT_W-1:0] bitCnt;
    logic             ovr;

    modport master (
        output init, start, serIn, sh_en, ack,
        input  dataOut, valid, busy, bitCnt, ovr
    );

    modport slave (
        input  init, start, serIn, sh_en, ack,
        output dataOut, valid, busy, bitCnt, ovr
    );
endinterface

// File: rtl/shift_deser_17b.sv
// Serial-to-parallel receiver for the left-shifting link: rebuilds WIDTH-bit frames MSB-first.
// Optional sticky overrun detection is built when SHIFT_DESER_OVR_DETECT_EN is defined.
module shift_deser_17b #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
) (
    input logic clk,
    input logic rst,
    shift_deser_17b_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] shReg;
    logic [WIDTH-1:0] dataOutQ;
    logic             validQ;
    logic             busyQ;
    logic [CNT_W-1:0] bitCnt;

    logic lastBit;
    assign lastBit = (bitCnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shReg    <= '0;
            dataOutQ <= '0;
            validQ   <= 1'b0;
            busyQ    <= 1'b0;
            bitCnt   <= '0;
        end else if (bus.init) begin
            state    <= IDLE;
            shReg    <= '0;
            dataOutQ <= '0;
            validQ   <= 1'b0;
            busyQ    <= 1'b0;
            bitCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RECV;
                        busyQ  <= 1'b1;
                        shReg  <= '0;
                        bitCnt <= '0;
                    end
                end
                RECV: begin
                    // start aborts the partial frame and wins over a coincident strobe
                    if (bus.start) begin
                        shReg  <= '0;
                        bitCnt <= '0;
                    end else if (bus.sh_en) begin
                        if (lastBit) begin
                            dataOutQ <= {shReg[WIDTH-2:0], bus.serIn};
                            shReg    <= '0;
                            validQ   <= 1'b1;
                            busyQ    <= 1'b0;
                            bitCnt   <= '0;
                            state    <= FULL;
                        end else begin
                            shReg  <= {shReg[WIDTH-2:0], bus.serIn};
                            bitCnt <= bitCnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.ack) begin
                        validQ <= 1'b0;
                        if (bus.start) begin
                            state  <= RECV;
                            busyQ  <= 1'b1;
                            shReg  <= '0;
                            bitCnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_DESER_OVR_DETECT_EN
    logic ovrQ;
    // sticky: dropped strobes while holding a frame, or a restart that discards bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovrQ <= 1'b0;
        else if (bus.init)
            ovrQ <= 1'b0;
        else if ((state == FULL && bus.sh_en) ||
                 (state == RECV && bus.start && bitCnt != '0))
            ovrQ <= 1'b1;
    end
    assign bus.ovr = ovrQ;
`else
    assign bus.ovr = 1'b0;
`endif

    assign bus.dataOut = dataOutQ;
    assign bus.valid   = validQ;
    assign bus.busy    = busyQ;
    assign bus.bitCnt  = bitCnt;
endmodule

// File: doc/shift_deser_17b.md
Name: shift_deser_17b

Overview:
Serial-to-parallel receiver for the SAYAC left-shifting serial link. The far-end shift register shifts left and drives its MSB (bit 16) out first. This block reassembles frames MSB-first into a WIDTH-bit word and presents it with a valid/ack handshake. Used wherever a serialised operand or result stream must be returned to parallel form, e.g. multiplier/divider datapath return or test access.

Parameters:
WIDTH, 17, frame length in bits and width of dataOut
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
init  input  1  synchronous clear; highest priority below rst
start  input  1  begin a new frame (1-cycle strobe)
serIn  input  1  serial data bit, MSB first
sh_en  input  1  bit strobe; serIn sampled on clk edge when high
ack  input  1  consumer accepts dataOut
dataOut  output  WIDTH  last completed frame
valid  output  1  dataOut holds an unacknowledged frame
busy  output  1  frame reception in progress
bitCnt  output  CNT_W  bits received in current frame
ovr  output  1  sticky overrun flag (see Optional Feature)

Behaviour:
- Reset values (rst=1, or init=1 at a clk edge): state IDLE, shift reg 0, dataOut 0, valid 0, busy 0, bitCnt 0, ovr 0. rst acts immediately, including mid-frame. init clears on the next clk edge, mid-frame included.
- States: IDLE, RECV, FULL. busy=1 only in RECV. valid=1 only in FULL. All outputs are registered.
- IDLE:
  - start=1 -> RECV; shift reg cleared; bitCnt=0.
  - sh_en and ack are ignored.
- RECV:
  - On each edge with sh_en=1: shreg <= {shreg[WIDTH-2:0], serIn}; bitCnt += 1.
  - Edges with sh_en=0 leave shreg and bitCnt unchanged. Gaps of any length are allowed.
  - WIDTH-th strobe (bitCnt==WIDTH-1 and sh_en=1): on that same edge, dataOut <= {shreg[WIDTH-2:0], serIn}; valid <= 1; bitCnt <= 0; state -> FULL.
  - Resulting latency: valid is high in the cycle immediately after the edge that samples the last bit.
  - start=1 in RECV aborts the current frame: shreg and bitCnt are cleared, state stays RECV, and any sh_en on that edge is discarded.
  - ack is ignored.
- FULL:
  - dataOut is held stable while valid=1.
  - ack=1, start=0 -> IDLE; valid=0 next cycle.
  - ack=1, start=1 -> RECV directly (back-to-back frames); valid=0, busy=1 next cycle.
  - start=1 without ack is ignored.
  - sh_en pulses are dropped, with no effect on shreg or dataOut (see ovr).
- Bit order: the first bit received lands in dataOut[WIDTH-1]; the last lands in dataOut[0].
- dataOut retains the previous frame through IDLE and RECV. It changes only on frame completion, rst, or init.
- bitCnt never exceeds WIDTH-1 and does not wrap mid-frame.

Optional Feature:
Macro: SHIFT_DESER_OVR_DETECT_EN
- Defined:
  - ovr is set on any edge where sh_en=1 while state is FULL.
  - ovr is also set on an edge where start=1 arrives in RECV with bitCnt!=0 (aborted partial frame).
  - Once set, ovr stays high until rst or init; ack does not clear it.
- Undefined: ovr is tied to 0 and no detection logic is built.

Test Plan:
1. Frame 17'h12345 sent MSB-first with sh_en high for 17 consecutive cycles after start -> valid=1 the cycle after the 17th bit; dataOut=17'h12345; busy=0; bitCnt=0.
2. Frame 17'h0AAAA with sh_en high on alternate cycles -> bitCnt advances only on strobes; dataOut=17'h0AAAA after the 17th strobe (34 cycles); no early valid.
3. Assert rst after 5 bits of 17'h1FFFF -> all outputs 0 immediately. Then assert init after 8 bits of a new frame -> IDLE, bitCnt=0, dataOut=0 next cycle.
4. Frame 17'h00F0F complete, ack held low for 10 cycles with 3 sh_en pulses -> dataOut stays 17'h00F0F and valid stays 1. With macro: ovr=1. Without macro: ovr=0. Then ack -> valid=0, state IDLE.
5. Frame 17'h1FFFF complete, ack+start in the same cycle, followed immediately by frame 17'h00001 -> valid drops for exactly one frame period; second dataOut=17'h00001.
6. Restart mid-frame: start after 9 bits, then a full 17'h15555 -> dataOut=17'h15555 (the partial frame has no effect). With macro: ovr=1.
